// File: rtl/ws2811_transmitter_if.sv
// Colour-fetch and line-drive signals between ledcontroller, the WS2811
// transmitter and the LED data pin.
interface ws2811_transmitter_if;
  logic       enable;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] ledindex;
  logic       dout;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, red, green, blue,
    input  ledindex, dout, busy, frame_done
  );

  modport slave (
    input  enable, red, green, blue,
    output ledindex, dout, busy, frame_done
  );
endinterface

// File: rtl/ws2811_transmitter.sv
// WS2811 serial output stage: sweeps ledindex, latches GRB words and drives the
// single-wire bit stream followed by the latch gap, prefetching the next LED.
module ws2811_transmitter #(
  parameter int NUM_LEDS = 64,
  parameter int TBIT     = 60,
  parameter int T0H      = 12,
  parameter int T1H      = 29,
  parameter int TRESET   = 2400,
  parameter int SETTLE   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ws2811_transmitter_if.slave  bus
);

  localparam int BW = $clog2(TBIT + 2);
  localparam int RW = $clog2(TRESET + 2);
  localparam int SW = $clog2(SETTLE + 2);

  localparam logic [BW-1:0] TBIT_LAST   = BW'(TBIT - 1);
  localparam logic [BW-1:0] T0H_C       = BW'(T0H);
  localparam logic [BW-1:0] T1H_C       = BW'(T1H);
  localparam logic [RW-1:0] TRESET_LAST = RW'(TRESET - 1);
  localparam logic [SW-1:0] SETTLE_C    = SW'(SETTLE);
  localparam logic [8:0]    LED_LAST    = 9'(NUM_LEDS - 1);
  localparam logic [7:0]    FIRST_IDX   = (NUM_LEDS == 1) ? 8'd0 : 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t        state_r;
  logic [23:0]   shreg_r;
  logic [BW-1:0] bit_cnt_r;
  logic [4:0]    bit_idx_r;
  logic [8:0]    led_cnt_r;
  logic [RW-1:0] latch_cnt_r;
  logic [SW-1:0] settle_cnt_r;
  logic [7:0]    ledindex_r;
  logic          dout_r;
  logic          busy_r;
  logic          frame_done_r;
  logic [8:0]    next_idx_s;

  function automatic logic [BW-1:0] high_time(input logic bit_val);
    return bit_val ? T1H_C : T0H_C;
  endfunction

  // Index of the LED to prefetch once the word now being loaded starts shifting.
  assign next_idx_s = led_cnt_r + 9'd2;

  // Frame sequencer: settle, shift words back to back, then hold the latch gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shreg_r      <= 24'd0;
      bit_cnt_r    <= '0;
      bit_idx_r    <= 5'd0;
      led_cnt_r    <= 9'd0;
      latch_cnt_r  <= '0;
      settle_cnt_r <= '0;
      ledindex_r   <= 8'd0;
      dout_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dout_r       <= 1'b0;
          ledindex_r   <= 8'd0;
          frame_done_r <= 1'b0;
          if (bus.enable) begin
            state_r      <= ST_PRIME;
            settle_cnt_r <= '0;
            busy_r       <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_PRIME: begin
          if (settle_cnt_r == SETTLE_C) begin
            shreg_r    <= {bus.green, bus.red, bus.blue};
            led_cnt_r  <= 9'd0;
            ledindex_r <= FIRST_IDX;
            bit_cnt_r  <= '0;
            bit_idx_r  <= 5'd0;
            dout_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_r != TBIT_LAST) begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
            dout_r    <= (bit_cnt_r + BW'(1)) < high_time(shreg_r[23]);
          end else if (bit_idx_r != 5'd23) begin
            bit_cnt_r <= '0;
            bit_idx_r <= bit_idx_r + 5'd1;
            shreg_r   <= {shreg_r[22:0], 1'b0};
            dout_r    <= 1'b1;
          end else if (led_cnt_r != LED_LAST) begin
            // Colour for this LED has been stable since the previous word load.
            shreg_r    <= {bus.green, bus.red, bus.blue};
            led_cnt_r  <= led_cnt_r + 9'd1;
            ledindex_r <= (next_idx_s > LED_LAST) ? 8'd0 : next_idx_s[7:0];
            bit_cnt_r  <= '0;
            bit_idx_r  <= 5'd0;
            dout_r     <= 1'b1;
          end else begin
            state_r      <= ST_LATCH;
            latch_cnt_r  <= '0;
            dout_r       <= 1'b0;
            frame_done_r <= (TRESET_LAST == RW'(0));
          end
        end
        ST_LATCH: begin
          dout_r <= 1'b0;
          if (latch_cnt_r == TRESET_LAST) begin
            frame_done_r <= 1'b0;
            settle_cnt_r <= '0;
            if (bus.enable) begin
              state_r <= ST_PRIME;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            latch_cnt_r  <= latch_cnt_r + RW'(1);
            frame_done_r <= ((latch_cnt_r + RW'(1)) == TRESET_LAST);
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          dout_r       <= 1'b0;
          ledindex_r   <= 8'd0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ledindex   = ledindex_r;
  assign bus.dout       = dout_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2811_transmitter.sv
// Bench for ws2811_transmitter: timeline model checked every cycle plus
// directed frame decoding against hand-computed words and timings.
module tb_ws2811_transmitter;
  localparam int N         = 2;
  localparam int TBIT      = 8;
  localparam int T0H       = 2;
  localparam int T1H       = 5;
  localparam int TRESET    = 20;
  localparam int SETTLE    = 4;
  localparam int D         = 24 * N * TBIT;
  localparam int FRAME_LEN = SETTLE + 1 + D + TRESET;
  localparam int LOGN      = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ovr = 1'b0;

  ws2811_transmitter_if bus();

  ws2811_transmitter #(
    .NUM_LEDS(N), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET), .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       dout_log [LOGN];
  logic       fd_log   [LOGN];
  logic [7:0] idx_log  [LOGN];

  // ledcontroller stand-in; ovr forces a glitch colour onto the bus.
  always_comb begin
    if (ovr) begin
      bus.red = 8'h12; bus.green = 8'h34; bus.blue = 8'h56;
    end else begin
      case (bus.ledindex)
        8'd0:    begin bus.red = 8'hFF; bus.green = 8'h00; bus.blue = 8'h0F; end
        8'd1:    begin bus.red = 8'h00; bus.green = 8'hA5; bus.blue = 8'h80; end
        default: begin bus.red = 8'h00; bus.green = 8'h00; bus.blue = 8'h00; end
      endcase
    end
  end

  function automatic logic [23:0] grb(input int led);
    if (led == 0) return {8'h00, 8'hFF, 8'h0F};
    else          return {8'hA5, 8'h00, 8'h80};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle model: position within a frame timeline derived from the sampling edge.
  initial begin
    logic       en_s, rs_s, m_active, e_dout, e_busy, e_fd, bv;
    logic [7:0] e_idx;
    int         m_k, j, led, bidx, ph;
    m_active = 1'b0;
    m_k = 0;
    forever begin
      @(posedge clk);
      en_s = bus.enable;
      rs_s = rst_n;
      cyc++;
      if (!rs_s) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (en_s) begin m_active = 1'b1; m_k = 0; end
      end else begin
        m_k++;
        if (m_k == FRAME_LEN) begin
          if (en_s) m_k = 0;
          else      m_active = 1'b0;
        end
      end
      #1;
      e_dout = 1'b0; e_busy = m_active; e_fd = 1'b0; e_idx = 8'd0;
      if (m_active && m_k > SETTLE && m_k < SETTLE + 1 + D) begin
        j    = m_k - SETTLE - 1;
        led  = j / (24 * TBIT);
        bidx = (j / TBIT) % 24;
        ph   = j % TBIT;
        bv   = grb(led) >> (23 - bidx);
        e_dout = (ph < (bv ? T1H : T0H));
        e_idx  = (led + 1 < N) ? 8'(led + 1) : 8'd0;
      end else if (m_active && m_k >= SETTLE + 1 + D) begin
        e_fd = (m_k == SETTLE + D + TRESET);
      end
      if (cyc < LOGN) begin
        dout_log[cyc] = bus.dout;
        fd_log[cyc]   = bus.frame_done;
        idx_log[cyc]  = bus.ledindex;
      end
      if (rst_n) begin
        check("model_dout", 32'(bus.dout), 32'(e_dout));
        check("model_busy", 32'(bus.busy), 32'(e_busy));
        check("model_ledindex", 32'(bus.ledindex), 32'(e_idx));
        check("model_frame_done", 32'(bus.frame_done), 32'(e_fd));
      end
    end
  end

  task automatic wait_done(output int fd_cyc);
    logic found;
    found = 1'b0;
    fd_cyc = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin found = 1'b1; fd_cyc = cyc; end
    end
    check("frame_done_timeout", 32'(found), 32'd1);
  endtask

  // Decode one logged frame whose first rise is expected at cycle r.
  task automatic check_frame(input int r, input string tag);
    logic [47:0] bits;
    int h, st, fdcnt;
    logic lowok;
    bits = 48'd0;
    check({tag, "_first_rise"}, 32'({dout_log[r-1], dout_log[r]}), 32'd1);
    for (int i = 0; i < 48; i++) begin
      st = r + i * TBIT;
      h = 0;
      while (h < TBIT && dout_log[st + h] === 1'b1) h++;
      lowok = 1'b1;
      for (int p = h; p < TBIT; p++) if (dout_log[st + p] !== 1'b0) lowok = 1'b0;
      bits = {bits[46:0], (h == T1H)};
      check($sformatf("%s_pulse%0d", tag, i), 32'((h == T0H || h == T1H) && lowok), 32'd1);
    end
    check({tag, "_word0"}, 32'(bits[47:24]), 32'h00FF0F);
    check({tag, "_word1"}, 32'(bits[23:0]), 32'hA50080);
    check({tag, "_idx_prime"}, 32'(idx_log[r-1]), 32'd0);
    check({tag, "_idx_led0"}, 32'(idx_log[r+191]), 32'd1);
    check({tag, "_idx_led1"}, 32'(idx_log[r+192]), 32'd0);
    lowok = 1'b1;
    fdcnt = 0;
    for (int c = r + D; c < r + D + TRESET; c++) begin
      if (dout_log[c] !== 1'b0) lowok = 1'b0;
      if (fd_log[c] === 1'b1) fdcnt++;
    end
    check({tag, "_latch_low"}, 32'(lowok), 32'd1);
    check({tag, "_fd_count"}, 32'(fdcnt), 32'd1);
    check({tag, "_fd_last"}, 32'(fd_log[r + D + TRESET - 1]), 32'd1);
  endtask

  initial begin
    int e, f1, f2, f3;
    bus.enable = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_dout", 32'(bus.dout), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ledindex", 32'(bus.ledindex), 32'd0);
    check("reset_frame_done", 32'(bus.frame_done), 32'd0);

    // Single frame from a one-cycle enable pulse.
    @(negedge clk); bus.enable = 1'b1; e = cyc + 1;
    @(negedge clk); bus.enable = 1'b0;
    wait_done(f1);
    check("single_fd_cycle", 32'(f1), 32'(e + 408));
    repeat (3) @(negedge clk);
    check("single_idle_busy", 32'(bus.busy), 32'd0);
    check_frame(e + 5, "single");

    // Glitch the colour inputs mid LED0 word.
    @(negedge clk); bus.enable = 1'b1; e = cyc + 1;
    @(negedge clk); bus.enable = 1'b0;
    while (cyc < e + 55) @(negedge clk);
    ovr = 1'b1;
    repeat (40) @(negedge clk);
    ovr = 1'b0;
    wait_done(f1);
    repeat (3) @(negedge clk);
    check_frame(e + 5, "prefetch");

    // Three back-to-back frames.
    @(negedge clk); bus.enable = 1'b1; e = cyc + 1;
    wait_done(f1);
    wait_done(f2);
    wait_done(f3);
    bus.enable = 1'b0;
    check("cont_fd1", 32'(f1), 32'(e + 408));
    check("cont_spacing12", 32'(f2 - f1), 32'd409);
    check("cont_spacing23", 32'(f3 - f2), 32'd409);
    repeat (5) @(negedge clk);
    check("cont_idle_busy", 32'(bus.busy), 32'd0);
    check_frame(e + 5, "cont0");
    check_frame(e + 5 + 409, "cont1");
    check_frame(e + 5 + 818, "cont2");

    // Enable dropped during LED0.
    @(negedge clk); bus.enable = 1'b1; e = cyc + 1;
    while (cyc < e + 105) @(negedge clk);
    bus.enable = 1'b0;
    wait_done(f1);
    check("drop_fd_cycle", 32'(f1), 32'(e + 408));
    repeat (3) @(negedge clk);
    check("drop_idle_busy", 32'(bus.busy), 32'd0);
    check_frame(e + 5, "drop");

    // Asynchronous reset during a high pulse.
    @(negedge clk); bus.enable = 1'b1; e = cyc + 1;
    @(negedge clk); bus.enable = 1'b0;
    while (cyc < e + 69) @(negedge clk);
    @(posedge clk);
    #2;
    check("rst_pre_high", 32'(bus.dout), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_dout", 32'(bus.dout), 32'd0);
    check("rst_async_busy", 32'(bus.busy), 32'd0);
    check("rst_async_ledindex", 32'(bus.ledindex), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.enable = 1'b1; e = cyc + 1;
    @(negedge clk); bus.enable = 1'b0;
    wait_done(f1);
    repeat (3) @(negedge clk);
    check_frame(e + 5, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
